// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI command front end and the register-bus slaves.
//   - Frame field positions inside byte0 = {rw, mod[1:0], ioc[4:0]}
//   - Module ID constants for the bus slaves
//   - Decoder FSM state encoding
//   - cmd_byte(): assembles a byte0 from its fields
package spi_bus_pkg;

  localparam int RW_BIT  = 7;
  localparam int MOD_MSB = 6;
  localparam int MOD_LSB = 5;
  localparam int IOC_MSB = 4;
  localparam int IOC_LSB = 0;

  localparam logic [1:0] MOD_SYS = 2'd0;
  localparam logic [1:0] MOD_IO  = 2'd1;
  localparam logic [1:0] MOD_SMI = 2'd2;
  localparam logic [1:0] MOD_RSV = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_DATA_TX,
    ST_DATA_RX,
    ST_STROBE,
    ST_DONE
  } state_e;

  function automatic logic [7:0] cmd_byte(input logic rw, input logic [1:0] mod,
                                          input logic [4:0] ioc);
    return {rw, mod, ioc};
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Register bus between the SPI command decoder and its slave modules.
//   o_ioc       register address (held for the whole frame)
//   o_data_out  write data
//   o_cs        one-hot module select, only during a strobe cycle
//   o_fetch_cmd 1-cycle read strobe
//   o_load_cmd  1-cycle write strobe
//   i_mod_data  read data, module k on [8k+7:8k]
// master = decoder side, slave = module side.
interface spi_cmd_decoder_if #(
  parameter int N_MODULES = 4
);
  logic [4:0]             o_ioc;
  logic [7:0]             o_data_out;
  logic [N_MODULES-1:0]   o_cs;
  logic                   o_fetch_cmd;
  logic                   o_load_cmd;
  logic [8*N_MODULES-1:0] i_mod_data;

  modport master (
    output o_ioc, o_data_out, o_cs, o_fetch_cmd, o_load_cmd,
    input  i_mod_data
  );

  modport slave (
    input  o_ioc, o_data_out, o_cs, o_fetch_cmd, o_load_cmd,
    output i_mod_data
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the system clock domain.
//   clk, rst   system clock, synchronous active-high reset
//   sck/ss_n/mosi  raw SPI pins
//   sck_rise   1-cycle pulse on a synchronised SCK rising edge
//   sck_fall   1-cycle pulse on a synchronised SCK falling edge
//   ss_act     synchronised slave select is active (low on the pin)
//   mosi_s     synchronised MOSI, aligned with sck_rise/sck_fall
module spi_edge_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_act,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ss_n_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_prev_q;

  // Synchroniser chains; MOSI goes through the same depth as SCK so the
  // sampled bit lines up with the detected edge. SS_N resets inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q      <= '0;
      ss_n_q     <= '1;
      mosi_q     <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_n_q     <= {ss_n_q[SYNC_STAGES-2:0], ss_n};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q <= sck_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_prev_q;
  assign ss_act   = ~ss_n_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI-slave (mode 0, MSB first) front end turning 2-byte host frames into
// register-bus cycles. Byte0 = {rw, mod, ioc}; byte1 is write data (rw=1) or
// the read byte returned on MISO (rw=0). Everything runs on i_sys_clk.
//   i_sys_clk, i_rst   system clock, synchronous active-high reset
//   i_spi_sck/ss_n/mosi  asynchronous SPI inputs
//   o_spi_miso         SPI data out, 0 outside the read data byte
//   bus                register bus (master side), see spi_cmd_decoder_if
module spi_cmd_decoder
  import spi_bus_pkg::*;
#(
  parameter int N_MODULES   = 4,
  parameter int SYNC_STAGES = 3
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst,
  input  logic                     i_spi_sck,
  input  logic                     i_spi_ss_n,
  input  logic                     i_spi_mosi,
  output logic                     o_spi_miso,
  spi_cmd_decoder_if.master        bus
);

  logic sck_rise, sck_fall, ss_act, mosi_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (i_sys_clk),
    .rst      (i_rst),
    .sck      (i_spi_sck),
    .ss_n     (i_spi_ss_n),
    .mosi     (i_spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_act   (ss_act),
    .mosi_s   (mosi_s)
  );

  state_e               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           cmd_sr_q, cmd_sr_d;
  logic [7:0]           data_sr_q, data_sr_d;
  logic [7:0]           tx_sr_q, tx_sr_d;
  logic [4:0]           ioc_q, ioc_d;
  logic [1:0]           mod_q, mod_d;

  logic                 mod_ok;
  logic [7:0]           rd_byte;
  logic                 fetch, load;
  logic [N_MODULES-1:0] cs;

  // Read-data mux; an out-of-range module leaves mod_ok low and the byte 0.
  always_comb begin
    rd_byte = '0;
    mod_ok  = 1'b0;
    for (int k = 0; k < N_MODULES; k++) begin
      if (int'(mod_q) == k) begin
        rd_byte = bus.i_mod_data[k*8 +: 8];
        mod_ok  = 1'b1;
      end
    end
  end

  // cs is tied to the strobe cycles so both always coincide.
  always_comb begin
    fetch = (state_q == ST_FETCH)  && mod_ok;
    load  = (state_q == ST_STROBE) && mod_ok;
    cs    = '0;
    for (int k = 0; k < N_MODULES; k++) begin
      cs[k] = (fetch || load) && (int'(mod_q) == k);
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_sr_d  = cmd_sr_q;
    data_sr_d = data_sr_q;
    tx_sr_d   = tx_sr_q;
    ioc_d     = ioc_q;
    mod_d     = mod_q;

    if (!ss_act) begin
      // Deselect aborts everything; a STROBE in progress still finishes
      // because the strobe is decoded from the current state.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      cmd_sr_d  = '0;
      data_sr_d = '0;
      tx_sr_d   = '0;
      ioc_d     = '0;
      mod_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (sck_rise) begin
            cmd_sr_d  = {cmd_sr_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ioc_d   = cmd_sr_d[IOC_MSB:IOC_LSB];
              mod_d   = cmd_sr_d[MOD_MSB:MOD_LSB];
              state_d = cmd_sr_d[RW_BIT] ? ST_DATA_RX : ST_FETCH;
            end
          end
        end
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_LOAD;
        ST_LOAD: begin
          // MISO is tx_sr[7], so bit 7 is on the pin as soon as this loads.
          tx_sr_d = rd_byte;
          state_d = ST_DATA_TX;
        end
        ST_DATA_TX: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              tx_sr_d = '0;
              state_d = ST_DONE;
            end
          end else if (sck_fall && bit_cnt_q != 3'd0) begin
            // The byte0 trailing fall can land here; only falls after a
            // byte1 rise advance the shifter.
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
        ST_DATA_RX: begin
          if (sck_rise) begin
            data_sr_d = {data_sr_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_STROBE;
            end
          end
        end
        ST_STROBE: state_d = ST_DONE;
        ST_DONE:   state_d = ST_DONE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      cmd_sr_q  <= '0;
      data_sr_q <= '0;
      tx_sr_q   <= '0;
      ioc_q     <= '0;
      mod_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_sr_q  <= cmd_sr_d;
      data_sr_q <= data_sr_d;
      tx_sr_q   <= tx_sr_d;
      ioc_q     <= ioc_d;
      mod_q     <= mod_d;
    end
  end

  assign o_spi_miso      = tx_sr_q[7];
  assign bus.o_ioc       = ioc_q;
  assign bus.o_data_out  = data_sr_q;
  assign bus.o_cs        = cs;
  assign bus.o_fetch_cmd = fetch;
  assign bus.o_load_cmd  = load;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: a bit-banged SPI master, register-file stub
// modules, and a scoreboard of expected strobes and MISO bytes checked by a
// separate monitor. A second instance with N_MODULES=2 on its own select
// line covers the out-of-range module case.
module tb_spi_cmd_decoder;
  import spi_bus_pkg::*;

  logic clk = 1'b0;
  logic rst, stub_init;
  logic sck, ss_n, ss2_n, mosi;
  logic miso, miso2;

  always #5 clk = ~clk;

  spi_cmd_decoder_if #(.N_MODULES(4)) bus ();
  spi_cmd_decoder_if #(.N_MODULES(2)) bus2 ();

  spi_cmd_decoder #(.N_MODULES(4), .SYNC_STAGES(3)) dut (
    .i_sys_clk (clk), .i_rst (rst), .i_spi_sck (sck), .i_spi_ss_n (ss_n),
    .i_spi_mosi (mosi), .o_spi_miso (miso), .bus (bus)
  );

  spi_cmd_decoder #(.N_MODULES(2), .SYNC_STAGES(3)) dut2 (
    .i_sys_clk (clk), .i_rst (rst), .i_spi_sck (sck), .i_spi_ss_n (ss2_n),
    .i_spi_mosi (mosi), .o_spi_miso (miso2), .bus (bus2)
  );

  typedef struct packed {
    logic       kind;   // 0 fetch, 1 load
    logic [3:0] cs;
    logic [4:0] ioc;
    logic [7:0] data;
  } strobe_t;

  strobe_t    exp_sq[$];
  logic [7:0] exp_mq[$];
  logic [7:0] obs_mq[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] model [4][32];
  logic [7:0] stub  [4][32];
  logic [7:0] mod_rd [4];

  function automatic logic [7:0] init_val(input int m, input int i);
    if (m == 1 && i == 0) return 8'h01;
    return 8'((m * 8'h35) ^ (i * 8'h0B) ^ 8'hC3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub slaves: register the addressed byte on fetch, store on load.
  always @(posedge clk) begin
    if (stub_init) begin
      for (int k = 0; k < 4; k++) begin
        mod_rd[k] <= 8'h00;
        for (int i = 0; i < 32; i++) stub[k][i] <= init_val(k, i);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.o_fetch_cmd && bus.o_cs[k]) mod_rd[k] <= stub[k][bus.o_ioc];
        if (bus.o_load_cmd && bus.o_cs[k]) stub[k][bus.o_ioc] <= bus.o_data_out;
      end
    end
  end

  assign bus.i_mod_data  = {mod_rd[3], mod_rd[2], mod_rd[1], mod_rd[0]};
  assign bus2.i_mod_data = 16'hFFFF;

  // Monitor: compares every strobe and every received MISO byte with the
  // expectations queued by the stimulus.
  always @(negedge clk) begin
    strobe_t e;
    logic [7:0] o, x;
    if (!rst) begin
      if (bus.o_fetch_cmd || bus.o_load_cmd) begin
        check("fetch_load_exclusive", 32'(bus.o_fetch_cmd & bus.o_load_cmd), 32'd0);
        if (exp_sq.size() == 0) begin
          check("unexpected_strobe", 32'({bus.o_fetch_cmd, bus.o_load_cmd}), 32'd0);
        end else begin
          e = exp_sq.pop_front();
          check("strobe_kind_load", 32'(bus.o_load_cmd), 32'(e.kind));
          check("strobe_cs", 32'(bus.o_cs), 32'(e.cs));
          check("strobe_ioc", 32'(bus.o_ioc), 32'(e.ioc));
          if (e.kind) check("strobe_data", 32'(bus.o_data_out), 32'(e.data));
        end
      end
      if (!ss2_n) begin
        check("oor_cs", 32'(bus2.o_cs), 32'd0);
        check("oor_strobes", 32'({bus2.o_fetch_cmd, bus2.o_load_cmd}), 32'd0);
      end
      while (obs_mq.size() > 0 && exp_mq.size() > 0) begin
        o = obs_mq.pop_front();
        x = exp_mq.pop_front();
        check("miso_byte", 32'(o), 32'(x));
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit on2,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      #40;
      rx[i] = on2 ? miso2 : miso;
      sck = 1'b1;
      #40;
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nextra,
                       input bit on2);
    logic [7:0] rx, exp1;
    int         m;
    strobe_t    e;
    m    = int'(b0[MOD_MSB:MOD_LSB]);
    exp1 = 8'h00;
    if (!on2) begin
      e.kind = b0[RW_BIT];
      e.cs   = 4'(1 << m);
      e.ioc  = b0[IOC_MSB:IOC_LSB];
      e.data = b1;
      exp_sq.push_back(e);
      if (b0[RW_BIT]) model[m][b0[4:0]] = b1;
      else            exp1 = model[m][b0[4:0]];
    end
    @(posedge clk);
    #($urandom_range(1, 9));
    if (on2) ss2_n = 1'b0; else ss_n = 1'b0;
    #40;
    exp_mq.push_back(8'h00);
    spi_bits(b0, 8, on2, rx);
    obs_mq.push_back(rx);
    exp_mq.push_back(exp1);
    spi_bits(b1, 8, on2, rx);
    obs_mq.push_back(rx);
    for (int n = 0; n < nextra; n++) begin
      exp_mq.push_back(8'h00);
      spi_bits(8'($urandom), 8, on2, rx);
      obs_mq.push_back(rx);
    end
    #40;
    ss_n  = 1'b1;
    ss2_n = 1'b1;
    #80;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ioc"}, 32'(bus.o_ioc), 32'd0);
    check({tag, "_data_out"}, 32'(bus.o_data_out), 32'd0);
    check({tag, "_cs"}, 32'(bus.o_cs), 32'd0);
    check({tag, "_strobes"}, 32'({bus.o_fetch_cmd, bus.o_load_cmd}), 32'd0);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_state_idle"}, 32'(dut.state_q), 32'(ST_IDLE));
    check({tag, "_bit_cnt"}, 32'(dut.bit_cnt_q), 32'd0);
    check({tag, "_cmd_sr"}, 32'(dut.cmd_sr_q), 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b1; stub_init = 1'b1;
    sck = 1'b0; mosi = 1'b0; ss_n = 1'b1; ss2_n = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 32; i++) model[k][i] = init_val(k, i);
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0; stub_init = 1'b0;
    repeat (5) @(negedge clk);

    // 1: write module 1, ioc 2, data 0x05
    frame(cmd_byte(1'b1, MOD_IO, 5'd2), 8'h05, 0, 1'b0);
    // 2: read module 1, ioc 0 -> 0x01
    frame(cmd_byte(1'b0, MOD_IO, 5'd0), 8'h00, 0, 1'b0);
    // read back what test 1 wrote, and a boundary address on module 0
    frame(cmd_byte(1'b0, MOD_IO, 5'd2), 8'h00, 0, 1'b0);
    frame(cmd_byte(1'b0, MOD_SYS, 5'd31), 8'h00, 0, 1'b0);

    // 3: abort a write after 5 bits of byte1, then a clean frame
    @(posedge clk); #3;
    ss_n = 1'b0;
    #40;
    exp_mq.push_back(8'h00);
    spi_bits(cmd_byte(1'b1, MOD_IO, 5'd9), 8, 1'b0, rx);
    obs_mq.push_back(rx);
    spi_bits(8'h5A, 5, 1'b0, rx);
    #40; ss_n = 1'b1; #80;
    frame(8'hA4, 8'h3C, 0, 1'b0);
    frame(cmd_byte(1'b0, MOD_IO, 5'd9), 8'h00, 0, 1'b0);

    // 4: write followed by two extra bytes
    frame(cmd_byte(1'b1, MOD_SMI, 5'd3), 8'h77, 2, 1'b0);
    frame(cmd_byte(1'b0, MOD_SMI, 5'd3), 8'h00, 1, 1'b0);

    // 5: out-of-range module on the 2-module instance, then reset mid-byte0
    frame(cmd_byte(1'b0, MOD_RSV, 5'd7), 8'h00, 0, 1'b1);
    frame(cmd_byte(1'b1, MOD_RSV, 5'd7), 8'hFF, 0, 1'b1);
    @(posedge clk); #3;
    ss_n = 1'b0;
    #40;
    spi_bits(8'hA5, 4, 1'b0, rx);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_outputs("rst_mid_byte0");
    ss_n = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #100;
    frame(cmd_byte(1'b1, MOD_SYS, 5'd17), 8'hC9, 0, 1'b0);

    // 6: random frames with random SCK phase
    for (int f = 0; f < 300; f++) begin
      frame(8'($urandom), 8'($urandom), 0, 1'b0);
    end

    repeat (20) @(negedge clk);
    check("strobes_pending", 32'(exp_sq.size()), 32'd0);
    check("miso_pending", 32'(exp_mq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
